multi_timer: RTL and testbench



---
 rtl/multi_timer.sv | 196 +++++++++++++++++++
 tb/tb_multi_timer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
`timescale 1ns/1ps
// Multi-channel up-counter peripheral on the two-phase select/enable slave bus.
// Each channel has a goal, prescaler, pause/resume, one-shot/auto-reload and a sticky DONE with maskable irq.
module multi_timer #(
    parameter int unsigned TIMER_BITS = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic                  enable,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [TIMER_BITS-1:0] wdata,
    output logic [TIMER_BITS-1:0] rdata,
    output logic                  ready,
    output logic                  slverr,
    output logic [CHANNELS-1:0]   irq
);

    // state | meaning
    // IDLE      | stopped, CURR holds last value
    // RUNNING   | counting prescaled ticks toward GOAL
    // COMPLETE  | one-shot reached GOAL, cleared to IDLE by a CTRL read
    // PAUSED    | STOP seen, CURR and prescale count frozen
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_COMPLETE = 2'd2,
        ST_PAUSED   = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] SUM_OFS = ADDR_WIDTH'(4 * CHANNELS);

    state_e                state_q [CHANNELS];
    state_e                state_d [CHANNELS];
    logic [TIMER_BITS-1:0] goal_q  [CHANNELS];
    logic [TIMER_BITS-1:0] goal_d  [CHANNELS];
    logic [TIMER_BITS-1:0] pre_q   [CHANNELS];
    logic [TIMER_BITS-1:0] pre_d   [CHANNELS];
    logic [TIMER_BITS-1:0] curr_q  [CHANNELS];
    logic [TIMER_BITS-1:0] curr_d  [CHANNELS];
    logic [TIMER_BITS-1:0] pcnt_q  [CHANNELS];
    logic [TIMER_BITS-1:0] pcnt_d  [CHANNELS];
    logic [CHANNELS-1:0]   auto_q, auto_d;
    logic [CHANNELS-1:0]   irqen_q, irqen_d;
    logic [CHANNELS-1:0]   done_q, done_d;

    logic                  access;
    logic [ADDR_WIDTH:0]   diff;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  chan_hit, sum_hit, addr_err, wr_ok, rd_ok;
    logic [2:0]            ch_sel;
    logic [1:0]            reg_sel;
    logic [CHANNELS-1:0]   wr_ctrl, wr_goal, wr_pre, rd_ctrl, start_req, stop_req;
    logic [TIMER_BITS-1:0] rd_val;

    assign access   = sel & enable;
    assign diff     = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign offset   = diff[ADDR_WIDTH-1:0];
    assign chan_hit = ~diff[ADDR_WIDTH] && (offset < SUM_OFS);
    assign sum_hit  = ~diff[ADDR_WIDTH] && (offset == SUM_OFS);
    assign ch_sel   = offset[4:2];
    assign reg_sel  = offset[1:0];
    // CURR and IRQ_SUM are read-only; writing them is an error without side effect
    assign addr_err = ~(chan_hit | sum_hit) | (write & (sum_hit | (reg_sel == 2'd2)));
    assign wr_ok    = access & write & ~addr_err;
    assign rd_ok    = access & ~write & ~addr_err;

    always_comb begin
        wr_ctrl   = '0;
        wr_goal   = '0;
        wr_pre    = '0;
        rd_ctrl   = '0;
        start_req = '0;
        stop_req  = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (chan_hit && ch_sel == 3'(ch)) begin
                wr_ctrl[ch] = wr_ok && reg_sel == 2'd0;
                wr_goal[ch] = wr_ok && reg_sel == 2'd1;
                wr_pre[ch]  = wr_ok && reg_sel == 2'd3;
                rd_ctrl[ch] = rd_ok && reg_sel == 2'd0;
            end
            // STOP dominates a simultaneous START
            start_req[ch] = wr_ctrl[ch] & wdata[0] & ~wdata[1];
            stop_req[ch]  = wr_ctrl[ch] & wdata[1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                state_q[ch] <= ST_IDLE;
                goal_q[ch]  <= '0;
                pre_q[ch]   <= '0;
                curr_q[ch]  <= '0;
                pcnt_q[ch]  <= '0;
            end
            auto_q  <= '0;
            irqen_q <= '0;
            done_q  <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                state_q[ch] <= state_d[ch];
                goal_q[ch]  <= goal_d[ch];
                pre_q[ch]   <= pre_d[ch];
                curr_q[ch]  <= curr_d[ch];
                pcnt_q[ch]  <= pcnt_d[ch];
            end
            auto_q  <= auto_d;
            irqen_q <= irqen_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        auto_d  = auto_q;
        irqen_d = irqen_q;
        done_d  = done_q;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            state_d[ch] = state_q[ch];
            goal_d[ch]  = goal_q[ch];
            pre_d[ch]   = pre_q[ch];
            curr_d[ch]  = curr_q[ch];
            pcnt_d[ch]  = pcnt_q[ch];

            if (wr_ctrl[ch]) begin
                auto_d[ch]  = wdata[4];
                irqen_d[ch] = wdata[5];
                if (wdata[6]) done_d[ch] = 1'b0;
            end
            if (wr_goal[ch]) goal_d[ch] = wdata;
            if (wr_pre[ch])  pre_d[ch]  = wdata;

            // DONE sets below come after the clear so a same-cycle set wins
            case (state_q[ch])
                ST_IDLE, ST_COMPLETE: begin
                    if (start_req[ch]) begin
                        curr_d[ch] = '0;
                        pcnt_d[ch] = '0;
                        if (goal_q[ch] == '0) begin
                            state_d[ch] = ST_COMPLETE;
                            done_d[ch]  = 1'b1;
                        end else begin
                            state_d[ch] = ST_RUNNING;
                        end
                    end else if (rd_ctrl[ch] && state_q[ch] == ST_COMPLETE) begin
                        state_d[ch] = ST_IDLE;
                    end
                end
                ST_RUNNING: begin
                    if (stop_req[ch]) begin
                        state_d[ch] = ST_PAUSED;
                    end else if (pcnt_q[ch] == pre_q[ch]) begin
                        pcnt_d[ch] = '0;
                        curr_d[ch] = TIMER_BITS'(curr_q[ch] + 1'b1);
                        if (TIMER_BITS'(curr_q[ch] + 1'b1) >= goal_q[ch]) begin
                            done_d[ch] = 1'b1;
                            if (auto_q[ch]) curr_d[ch]  = '0;
                            else            state_d[ch] = ST_COMPLETE;
                        end
                    end else begin
                        pcnt_d[ch] = TIMER_BITS'(pcnt_q[ch] + 1'b1);
                    end
                end
                ST_PAUSED: begin
                    if (start_req[ch]) state_d[ch] = ST_RUNNING;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        if (sum_hit) rd_val[CHANNELS-1:0] = irq;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (chan_hit && ch_sel == 3'(ch)) begin
                case (reg_sel)
                    2'd0:    rd_val[6:0] = {done_q[ch], irqen_q[ch], auto_q[ch], state_q[ch], 2'b00};
                    2'd1:    rd_val = goal_q[ch];
                    2'd2:    rd_val = curr_q[ch];
                    default: rd_val = pre_q[ch];
                endcase
            end
        end
    end

    assign irq    = done_q & irqen_q;
    assign ready  = access;
    assign slverr = access & addr_err;
    assign rdata  = rd_ok ? rd_val : '0;

endmodule

// File: tb/tb_multi_timer.sv
`timescale 1ns/1ps
// Self-checking bench for multi_timer: directed scenarios plus randomized channel runs
// compared against an arithmetic tick model (ticks = elapsed / (PRESCALE+1)).
module tb_multi_timer;
    localparam int TB = 8;
    localparam int AW = 32;
    localparam int CH = 4;
    localparam logic [AW-1:0] BASE = 32'h20;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sel = 1'b0, enable = 1'b0, write = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [TB-1:0] wdata = '0;
    logic [TB-1:0] rdata;
    logic          ready, slverr;
    logic [CH-1:0] irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    multi_timer #(.TIMER_BITS(TB), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .CHANNELS(CH)) dut (
        .clk(clk), .reset(reset), .sel(sel), .enable(enable), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .slverr(slverr), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] ra(input int ch, input int r);
        return BASE + AW'(4 * ch + r);
    endfunction

    function automatic logic [7:0] ctrl_val(input int st, input int au, input int ie, input int dn);
        return 8'((dn << 6) | (ie << 5) | (au << 4) | (st << 2));
    endfunction

    // Expected CURR/STATE/DONE n edges after a START from IDLE with goal g >= 1
    function automatic void model(input int n, input int g, input int p, input int au,
                                  output int curr, output int st, output int dn);
        int ticks;
        ticks = n / (p + 1);
        dn = (ticks >= g) ? 1 : 0;
        if (au != 0) begin
            curr = ticks % g;
            st   = 1;
        end else if (ticks >= g) begin
            curr = g;
            st   = 2;
        end else begin
            curr = ticks;
            st   = 1;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [7:0] d, output logic err, output logic rdy);
        @(posedge clk); #1;
        sel = 1'b1; enable = 1'b0; write = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        enable = 1'b1;
        #1;
        err = slverr; rdy = ready;
        @(posedge clk); #1;
        sel = 1'b0; enable = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [7:0] d, output logic err,
                            output logic rdy, output int ed);
        @(posedge clk); #1;
        sel = 1'b1; enable = 1'b0; write = 1'b0; addr = a;
        @(posedge clk); #1;
        enable = 1'b1;
        #1;
        d = rdata; err = slverr; rdy = ready; ed = cyc;
        @(posedge clk); #1;
        sel = 1'b0; enable = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        logic e, r;
        bus_write(a, d, e, r);
        chk("wr_resp", {30'd0, r, e}, 32'd2);
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [7:0] d, output int ed);
        logic e, r;
        bus_read(a, d, e, r, ed);
        chk("rd_resp", {30'd0, r, e}, 32'd2);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       e, r;
        int t0, t1, t2, ed, held, mc, ms, md;
        int rch, g, p, au, ie, w;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_bus", {29'd0, ready, slverr, |rdata}, 32'd0);
        reset = 1'b1;
        rd(ra(0, 0), d, ed); chk("rst_ctrl0", 32'(d), 32'd0);
        rd(ra(2, 2), d, ed); chk("rst_curr2", 32'(d), 32'd0);

        // bus errors
        bus_write(BASE + AW'(4 * CH + 1), 8'hFF, e, r);
        chk("bad_wr_resp", {30'd0, r, e}, 32'd3);
        bus_read(BASE + AW'(4 * CH + 1), d, e, r, ed);
        chk("bad_rd_resp", {30'd0, r, e}, 32'd3);
        chk("bad_rd_data", 32'(d), 32'd0);
        @(posedge clk); #1;
        addr = ra(0, 0); wdata = 8'h01; write = 1'b1; enable = 1'b1;
        #1;
        chk("nosel_ready", {30'd0, ready, slverr}, 32'd0);
        @(posedge clk); #1;
        enable = 1'b0; write = 1'b0;
        rd(ra(0, 0), d, ed); chk("nosel_noeffect", 32'(d), 32'd0);
        bus_write(ra(0, 2), 8'h33, e, r);
        chk("curr_wr_err", {30'd0, r, e}, 32'd3);
        rd(ra(0, 2), d, ed); chk("curr_unchanged", 32'(d), 32'd0);
        rd(BASE + AW'(4 * CH), d, ed); chk("irqsum_zero", 32'(d), 32'd0);

        // one-shot on channel 0, goal 25, no prescale
        wr(ra(0, 1), 8'd25);
        wr(ra(0, 3), 8'd0);
        wr(ra(0, 0), 8'h01); t0 = cyc;
        rd(ra(0, 0), d, ed); model(ed - t0, 25, 0, 0, mc, ms, md);
        chk("os_running", 32'(d), 32'(ctrl_val(ms, 0, 0, md)));
        wait_until(t0 + 22);
        rd(ra(0, 2), d, ed); model(ed - t0, 25, 0, 0, mc, ms, md);
        chk("os_curr_before", 32'(d), 32'(mc));
        rd(ra(0, 0), d, ed); model(ed - t0, 25, 0, 0, mc, ms, md);
        chk("os_complete", 32'(d), 32'(ctrl_val(ms, 0, 0, md)));
        rd(ra(0, 2), d, ed); chk("os_curr_final", 32'(d), 32'd25);
        rd(ra(0, 0), d, ed); chk("os_idle_after_read", 32'(d), 32'(ctrl_val(0, 0, 0, 1)));

        // pause/resume on channel 1
        wr(ra(1, 1), 8'd25);
        wr(ra(1, 0), 8'h01); t0 = cyc;
        wait_until(t0 + 6);
        wr(ra(1, 0), 8'h03); t1 = cyc;
        held = t1 - 1 - t0;
        rd(ra(1, 0), d, ed); chk("pause_state", 32'(d), 32'(ctrl_val(3, 0, 0, 0)));
        rd(ra(1, 2), d, ed); chk("pause_held_a", 32'(d), 32'(held));
        repeat (10) @(posedge clk);
        #1;
        rd(ra(1, 2), d, ed); chk("pause_held_b", 32'(d), 32'(held));
        wr(ra(1, 0), 8'h01); t2 = cyc;
        wait_until(t2 + 1);
        rd(ra(1, 2), d, ed); chk("resume_curr", 32'(d), 32'(held + (ed - t2)));
        wait_until(t2 + (25 - held));
        rd(ra(1, 0), d, ed); chk("resume_complete", 32'(d), 32'(ctrl_val(2, 0, 0, 1)));
        rd(ra(1, 2), d, ed); chk("resume_final", 32'(d), 32'd25);

        // prescaler and interrupt on channel 2
        wr(ra(2, 3), 8'd3);
        wr(ra(2, 1), 8'd4);
        wr(ra(2, 0), 8'h21); t0 = cyc;
        while (irq[2] !== 1'b1 && cyc < t0 + 40) begin
            @(posedge clk); #1;
        end
        chk("irq2_rise_delay", 32'(cyc - t0), 32'd16);
        rd(BASE + AW'(4 * CH), d, ed); chk("irqsum_ch2", 32'(d), 32'h04);
        wr(ra(2, 0), 8'h60);
        chk("irq2_cleared", 32'(irq), 32'd0);

        // auto-reload on channel 3, goal 5
        wr(ra(3, 1), 8'd5);
        wr(ra(3, 0), 8'h11); t0 = cyc;
        wait_until(t0 + 3);
        rd(ra(3, 2), d, ed); model(ed - t0, 5, 0, 1, mc, ms, md);
        chk("auto_wrap1", 32'(d), 32'(mc));
        rd(ra(3, 0), d, ed); model(ed - t0, 5, 0, 1, mc, ms, md);
        chk("auto_ctrl", 32'(d), 32'(ctrl_val(ms, 1, 0, md)));
        wait_until(t0 + 8);
        rd(ra(3, 2), d, ed); model(ed - t0, 5, 0, 1, mc, ms, md);
        chk("auto_wrap2", 32'(d), 32'(mc));

        // goal 0 start completes at once; DONE set beats the clear in the same write
        wr(ra(0, 1), 8'd0);
        wr(ra(0, 0), 8'h41);
        rd(ra(0, 0), d, ed); chk("goal0_complete", 32'(d), 32'(ctrl_val(2, 0, 0, 1)));
        rd(ra(0, 0), d, ed); chk("goal0_idle", 32'(d), 32'(ctrl_val(0, 0, 0, 1)));

        // asynchronous reset in the middle of a count
        wr(ra(3, 0), 8'h30);
        chk("irq3_enabled", 32'(irq), 32'h8);
        wr(ra(0, 1), 8'd200);
        wr(ra(0, 0), 8'h01);
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_irq", 32'(irq), 32'd0);
        chk("async_rst_bus", {29'd0, ready, slverr, |rdata}, 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        rd(ra(0, 0), d, ed); chk("post_rst_ctrl0", 32'(d), 32'd0);
        rd(ra(0, 2), d, ed); chk("post_rst_curr0", 32'(d), 32'd0);
        rd(ra(3, 0), d, ed); chk("post_rst_ctrl3", 32'(d), 32'd0);

        // randomized single-channel runs against the tick model
        for (int it = 0; it < 10; it++) begin
            #2 reset = 1'b0;
            #2 reset = 1'b1;
            @(posedge clk); #1;
            rch = $urandom_range(0, CH - 1);
            g   = $urandom_range(1, 12);
            p   = $urandom_range(0, 3);
            au  = $urandom_range(0, 1);
            ie  = $urandom_range(0, 1);
            w   = $urandom_range(0, 60);
            wr(ra(rch, 1), 8'(g));
            wr(ra(rch, 3), 8'(p));
            wr(ra(rch, 0), ctrl_val(0, au, ie, 0) | 8'h01); t0 = cyc;
            repeat (w) @(posedge clk);
            #1;
            rd(ra(rch, 2), d, ed); model(ed - t0, g, p, au, mc, ms, md);
            chk("rand_curr", 32'(d), 32'(mc));
            rd(ra(rch, 0), d, ed); model(ed - t0, g, p, au, mc, ms, md);
            chk("rand_ctrl", 32'(d), 32'(ctrl_val(ms, au, ie, md)));
            model(cyc - t0, g, p, au, mc, ms, md);
            chk("rand_irq", 32'(irq), 32'((md & ie) << rch));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
